// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 32-bit register bank.
package regfile_pkg;

  localparam int DW     = 32;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int BE_W   = DW / 8;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DW-1:0]     reg_word_t;

  function automatic int unsigned slice_lo(input int unsigned n);
    return DW * n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservation handshake, write-back clear and
// registered pulse for writes to registers that were never reserved.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  reg_addr_t       wr_addr,
  input  logic            rsv_valid,
  input  reg_addr_t       rsv_addr,
  output logic            rsv_ready,
  output logic [NREG-1:0] busy,
  output logic            err_unres
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;
  logic            wr_zero, rsv_zero;

  assign wr_zero  = ZERO_REG && (wr_addr == '0);
  assign rsv_zero = ZERO_REG && (rsv_addr == '0);

  // A same-cycle write to the reserved address frees it in time for the new owner.
  assign rsv_ready = !busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)) || rsv_zero;

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (rsv_valid && rsv_ready && !rsv_zero) busy_d[rsv_addr] = 1'b1;
    err_d = wr_en && !busy_q[wr_addr] && !wr_zero;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy      = busy_q;
  assign err_unres = err_q;

endmodule

// File: rtl/regfile_bank32.sv
// 32 x 32-bit register bank with byte-enabled write port and busy scoreboard.
// Optional macro REGFILE_WR_FWD_EN forwards the current write onto rf_flat.
module regfile_bank32
  import regfile_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  reg_addr_t          wr_addr,
  input  reg_word_t          wr_data,
  input  logic [BE_W-1:0]    wr_be,
  input  logic               rsv_valid,
  input  reg_addr_t          rsv_addr,
  output logic               rsv_ready,
  output logic [NREG*DW-1:0] rf_flat,
  output logic [NREG-1:0]    busy,
  output logic               err_unres
);

  reg_word_t regs [NREG];
  logic      wr_zero;

  assign wr_zero = ZERO_REG && (wr_addr == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < NREG; n++) regs[n] <= '0;
    end else if (wr_en && !wr_zero) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wr_be[k]) regs[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NREG; n++) rf_flat[slice_lo(n) +: DW] = regs[n];
`ifdef REGFILE_WR_FWD_EN
    if (wr_en && !wr_zero) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wr_be[k]) rf_flat[slice_lo(int'(wr_addr)) + 8*k +: 8] = wr_data[8*k +: 8];
      end
    end
`endif
  end

  regfile_scoreboard #(
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy      (busy),
    .err_unres (err_unres)
  );

endmodule

// File: doc/regfile_bank32.md
Name: regfile_bank32

Overview:
- Storage stage directly upstream of the 32:1 x 32-bit read multiplexer.
- Holds 32 general registers of 32 bits and presents every register value in parallel on a flat bus, which is sliced into the mux data inputs i0..i31.
- Provides one byte-enabled synchronous write port.
- Provides a busy-bit scoreboard: issue logic reserves a destination register, and the write-back clears the reservation.

Parameters:
- DW, 32, register width in bits; must be a multiple of 8.
- NREG, 32, number of registers; the address width is 5.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked busy.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr_en  in  1  write strobe for the current cycle.
- wr_addr  in  5  destination register for the write.
- wr_data  in  DW  write data.
- wr_be  in  DW/8  byte enables; bit k covers data bits [8k+7:8k].
- rsv_valid  in  1  request to reserve a register.
- rsv_addr  in  5  register to reserve.
- rsv_ready  out  1  reservation is accepted this cycle.
- rf_flat  out  NREG*DW  all register values; register n occupies [DW*n+DW-1:DW*n].
- busy  out  NREG  per-register pending-write flags.
- err_unres  out  1  one-cycle pulse when a write targets a register that is not busy.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all registers are set to 0;
  - busy is set to 0;
  - err_unres is set to 0.
  - Reset overrides any write or reservation presented in the same cycle.
  - Reset asserted mid-operation discards all pending reservations.
- Write:
  - When wr_en=1, each byte of register wr_addr with wr_be[k]=1 takes the matching byte of wr_data on the rising edge. Bytes with wr_be[k]=0 hold their value.
  - The new value appears on rf_flat one cycle after the edge, i.e. write latency is 1.
  - wr_en=1 with wr_be=0 modifies no data but still clears busy.
- ZERO_REG=1 and wr_addr=0: no data change, no error pulse, and busy[0] stays 0.
- Reservation handshake:
  - rsv_ready = !busy[rsv_addr], or a write in the same cycle clears that same address, or (ZERO_REG=1 and rsv_addr=0).
  - rsv_ready is combinational and independent of rsv_valid.
  - When rsv_valid and rsv_ready are both 1, busy[rsv_addr] is set on the edge.
  - When rsv_valid=1 and rsv_ready=0, the caller must hold the request. There is no queueing.
- Busy clear: a write with wr_en=1 clears busy[wr_addr] on the edge.
- Write and reservation to the same address in the same cycle:
  - the data is written;
  - busy ends at 1 (the new reservation wins);
  - rsv_ready=1.
- Write and reservation to different addresses: both take effect independently.
- err_unres: registered. It is 1 for exactly one cycle after an edge at which wr_en=1 and busy[wr_addr]=0, excluding register 0 when ZERO_REG=1. The data is still written.
- All outputs are registered except rsv_ready; in the optional mode below, rf_flat is also bypassed combinationally.

Optional Feature:
- Macro: REGFILE_WR_FWD_EN.
- Defined: a write is forwarded combinationally onto rf_flat in the same cycle. For each byte with wr_be[k]=1, the slice of register wr_addr shows wr_data, so the downstream mux sees the new value with 0-cycle latency. This is suppressed for register 0 when ZERO_REG=1.
- Undefined: rf_flat comes purely from the register array, with 1-cycle write latency.

Decomposition:
- Shared package regfile_pkg:
  - constants DW, NREG, ADDR_W=5, BE_W=DW/8;
  - typedef reg_addr_t (logic [4:0]);
  - typedef reg_word_t (logic [DW-1:0]);
  - function slice_lo(n) returning DW*n.
- Sub-module regfile_scoreboard: busy vector, rsv_ready logic, err_unres generation.
- The data array and byte-enable write logic stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with wr_en=1, wr_addr=5, wr_data=32'hFFFF_FFFF → after release, rf_flat all 0, busy=0, err_unres=0.
- Reserve then write: reserve 7 (rsv_ready=1), then write 32'hDEAD_BEEF with wr_be=4'hF to 7 → busy[7]=1 after the first edge; register 7 = DEAD_BEEF and busy[7]=0 after the second; no err pulse.
- Byte enables: register 3 = 32'h1122_3344; reserve 3; write 32'hAABB_CCDD with wr_be=4'b0101 → register 3 = 32'h11BB_33DD.
- WAW stall: busy[9]=1 and rsv_valid=1, rsv_addr=9, no write → rsv_ready=0 and busy unchanged. In the same cycle add wr_en=1 to 9 → rsv_ready=1 and busy[9] remains 1.
- Unreserved write: write 32'h5 to 12 with busy[12]=0 → register 12 = 5, err_unres=1 for exactly one cycle. Write to 0 with ZERO_REG=1 → register 0 stays 0, no err.
- With REGFILE_WR_FWD_EN: wr_en=1 to 4 with data 32'hCAFE_0001 → slice 4 of rf_flat equals CAFE_0001 in the same cycle. Without the macro it shows the old value until the next cycle.
